// File: rtl/fm_demod.sv
// fm_demod: sequential FM discriminator (conjugate product, divide-based arctan, gain).
// Define FM_DEMOD_OVERRUN_EN to add a sticky overrun flag for samples dropped while busy.
module fm_demod #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 10,
  parameter int QUAD1      = 804,
  parameter int QUAD3      = 2412,
  parameter int GAIN       = 758
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] newDataReal,
  input  logic signed [DATA_WIDTH-1:0] newDataImag,
  input  logic                         newDataAvailable,
  output logic                         ready,
  output logic signed [DATA_WIDTH-1:0] demodData,
  output logic                         done
`ifdef FM_DEMOD_OVERRUN_EN
  ,
  output logic                         overrun
`endif
);

  // state | meaning
  // IDLE  | waiting for a sample, ready=1
  // MULT  | conjugate product of prev and cur, prev <= cur
  // PREP  | build numerator/denominator, load divider
  // DIV   | one quotient bit per cycle, DATA_WIDTH cycles
  // ANGLE | angle from quotient, gain applied, demodData loaded
  // DONE  | done strobe, back to IDLE
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MULT  = 3'd1;
  localparam logic [2:0] S_PREP  = 3'd2;
  localparam logic [2:0] S_DIV   = 3'd3;
  localparam logic [2:0] S_ANGLE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic signed [PW-1:0]         Q1_W   = PW'(QUAD1);
  localparam logic signed [PW-1:0]         GAIN_W = PW'(GAIN);
  localparam logic signed [DATA_WIDTH-1:0] Q1_D   = DATA_WIDTH'(QUAD1);
  localparam logic signed [DATA_WIDTH-1:0] Q3_D   = DATA_WIDTH'(QUAD3);

  logic [2:0]                  state;
  logic signed [DATA_WIDTH-1:0] cur_r, cur_i, prev_r, prev_i, re, im;
  logic [DATA_WIDTH-1:0]       den, quo, rem;
  logic                        neg;
  logic [CW-1:0]               cnt;

  assign ready = (state == S_IDLE);

  logic signed [PW-1:0]         p_re, p_im;
  logic signed [DATA_WIDTH-1:0] re_c, im_c;
  always_comb begin
    p_re = PW'(prev_r) * PW'(cur_r) + PW'(prev_i) * PW'(cur_i);
    p_im = PW'(prev_r) * PW'(cur_i) - PW'(prev_i) * PW'(cur_r);
    re_c = DATA_WIDTH'(p_re >>> FRAC_BITS);
    im_c = DATA_WIDTH'(p_im >>> FRAC_BITS);
  end

  // ay >= 1 keeps the denominator strictly positive in both half-planes
  logic signed [DATA_WIDTH-1:0] ay, num, den_c;
  logic [DATA_WIDTH-1:0]        num_mag;
  always_comb begin
    ay = (im[DATA_WIDTH-1] ? -im : im) + DATA_WIDTH'(1);
    if (!re[DATA_WIDTH-1]) begin
      num   = (re - ay) <<< FRAC_BITS;
      den_c = re + ay;
    end else begin
      num   = (re + ay) <<< FRAC_BITS;
      den_c = ay - re;
    end
    num_mag = num[DATA_WIDTH-1] ? DATA_WIDTH'(-num) : num;
  end

  // Restoring divider on magnitudes; sign reapplied afterwards gives truncation toward zero
  logic [DATA_WIDTH:0]   rem_sh, rem_sub;
  logic                  rem_ge;
  logic [DATA_WIDTH-1:0] rem_nx;
  always_comb begin
    rem_sh  = {rem, quo[DATA_WIDTH-1]};
    rem_sub = rem_sh - {1'b0, den};
    rem_ge  = (rem_sh >= {1'b0, den});
    rem_nx  = DATA_WIDTH'(rem_ge ? rem_sub : rem_sh);
  end

  logic signed [DATA_WIDTH-1:0] q, ang, demod_c;
  logic signed [PW-1:0]         q_prod, g_prod;
  always_comb begin
    q      = neg ? -$signed(quo) : $signed(quo);
    q_prod = Q1_W * PW'(q);
    ang    = (re[DATA_WIDTH-1] ? Q3_D : Q1_D) - DATA_WIDTH'(q_prod >>> FRAC_BITS);
    if (im[DATA_WIDTH-1]) ang = -ang;
    g_prod  = GAIN_W * PW'(ang);
    demod_c = DATA_WIDTH'(g_prod >>> FRAC_BITS);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_r     <= '0;
      cur_i     <= '0;
      prev_r    <= '0;
      prev_i    <= '0;
      re        <= '0;
      im        <= '0;
      den       <= '0;
      quo       <= '0;
      rem       <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
      demodData <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (newDataAvailable) begin
            cur_r <= newDataReal;
            cur_i <= newDataImag;
            state <= S_MULT;
          end
        end
        S_MULT: begin
          re     <= re_c;
          im     <= im_c;
          prev_r <= cur_r;
          prev_i <= cur_i;
          state  <= S_PREP;
        end
        S_PREP: begin
          den   <= den_c;
          quo   <= num_mag;
          rem   <= '0;
          neg   <= num[DATA_WIDTH-1];
          cnt   <= CW'(DATA_WIDTH - 1);
          state <= S_DIV;
        end
        S_DIV: begin
          rem <= rem_nx;
          quo <= {quo[DATA_WIDTH-2:0], rem_ge};
          if (cnt == '0) state <= S_ANGLE;
          else cnt <= cnt - 1'b1;
        end
        S_ANGLE: begin
          demodData <= demod_c;
          done      <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FM_DEMOD_OVERRUN_EN
  always_ff @(posedge clock) begin
    if (reset) overrun <= 1'b0;
    else if (newDataAvailable && !ready) overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_fm_demod.sv
// Testbench for fm_demod: directed and random samples, scoreboard checked against an
// arithmetic reference model; timing is predicted from the fixed accept-to-done schedule.
`timescale 1ns/1ps
module tb_fm_demod;
  localparam int     DW = 32, FB = 10, Q1 = 804, Q3 = 2412, GN = 758;
  localparam longint LAT = 36;     // accept edge to the edge that ends the done cycle
  localparam longint PERIOD = 37;  // accept to next possible accept

  logic clock = 1'b0, reset = 1'b1, nda = 1'b0;
  logic signed [DW-1:0] din_r = '0, din_i = '0;
  logic ready, done;
  logic signed [DW-1:0] demod;
`ifdef FM_DEMOD_OVERRUN_EN
  logic overrun;
`endif

  fm_demod dut (
    .clock(clock), .reset(reset),
    .newDataReal(din_r), .newDataImag(din_i), .newDataAvailable(nda),
    .ready(ready), .demodData(demod), .done(done)
`ifdef FM_DEMOD_OVERRUN_EN
    , .overrun(overrun)
`endif
  );

  always #5 clock = ~clock;

  typedef struct { longint acc; longint dne; int val; } exp_t;
  exp_t sbq[$];
  int total = 0, bad = 0;
  longint cyc = 0;
  logic rst_at_edge = 1'b0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    rst_at_edge <= reset;
  end

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: conjugate product, ratio-based arctan, gain, all in plain integer arithmetic.
  function automatic int model(input int pr, input int pi, input int cr, input int ci);
    longint re, im, ay, num, den, q, ang;
    re = (longint'(pr) * cr + longint'(pi) * ci) >>> FB;
    im = (longint'(pr) * ci - longint'(pi) * cr) >>> FB;
    ay = ((im < 0) ? -im : im) + 1;
    if (re >= 0) begin
      num = (re - ay) * (1 << FB);
      den = re + ay;
    end else begin
      num = (re + ay) * (1 << FB);
      den = ay - re;
    end
    q = num / den;
    ang = ((re >= 0) ? Q1 : Q3) - ((Q1 * q) >>> FB);
    if (im < 0) ang = -ang;
    return int'((GN * ang) >>> FB);
  endfunction

  int     m_pr = 0, m_pi = 0;
  longint m_free = 0;
  bit     m_known = 1'b0, m_ovr = 1'b0;

  // One cycle of stimulus for the upcoming edge (cyc+1); the model decides acceptance.
  task automatic drive(input bit rst, input bit v, input int r, input int i,
                       input bit use_c = 1'b0, input int cval = 0);
    bit   exp_rdy;
    exp_t e;
    @(negedge clock);
    exp_rdy = (cyc + 1 >= m_free);
    if (m_known) begin
      chk("ready", longint'(ready), longint'(exp_rdy));
`ifdef FM_DEMOD_OVERRUN_EN
      chk("overrun", longint'(overrun), longint'(m_ovr));
`endif
    end
    reset = rst;
    nda   = v;
    din_r = r;
    din_i = i;
    if (rst) begin
      m_pr = 0; m_pi = 0; m_ovr = 1'b0; m_known = 1'b1;
      m_free = cyc + 2;
    end else if (v) begin
      if (exp_rdy) begin
        e.acc = cyc + 1;
        e.dne = cyc + LAT;
        e.val = use_c ? cval : model(m_pr, m_pi, r, i);
        sbq.push_back(e);
        m_pr = r; m_pi = i;
        m_free = cyc + 1 + PERIOD;
      end else begin
        m_ovr = 1'b1;
      end
    end
  endtask

  task automatic wait_free();
    while (cyc + 2 < m_free) drive(1'b0, 1'b0, 0, 0);
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, 32767)) - 16384;
  endfunction

  // Monitor: pops expectations whenever done is presented
  int   exp_hold = 0;
  bit   mon_known = 1'b0;
  exp_t me;
  always @(negedge clock) begin
    if (rst_at_edge) begin
      while (sbq.size() > 0 && sbq[0].acc <= cyc) void'(sbq.pop_front());
      exp_hold  = 0;
      mon_known = 1'b1;
    end
    if (mon_known) begin
      if (done) begin
        if (sbq.size() == 0) begin
          chk("done_unexpected", longint'(done), 0);
        end else begin
          me = sbq.pop_front();
          chk("done_cycle", cyc, me.dne);
          chk("demod_value", longint'(demod), longint'(me.val));
          exp_hold = me.val;
        end
      end else begin
        chk("demod_hold", longint'(demod), longint'(exp_hold));
        if (sbq.size() > 0 && cyc > sbq[0].dne) begin
          me = sbq.pop_front();
          chk("done_missing", cyc, me.dne);
        end
      end
    end
  end

  initial begin
    repeat (3) drive(1'b1, 1'b0, 0, 0);

    // first sample after reset, then the same sample again
    drive(1'b0, 1'b1, 1024, 0, 1'b1, 1190); wait_free();
    drive(1'b0, 1'b1, 1024, 0); wait_free();

    // negative phase
    drive(1'b1, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 1024, 0, 1'b1, 1190); wait_free();
    drive(1'b0, 1'b1, 0, -1024, 1'b1, -1191); wait_free();

    // busy drop at accept+5; the following result depends on prev being the first sample
    drive(1'b1, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 1024, 0, 1'b1, 1190);
    repeat (4) drive(1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 777, -555);
    wait_free();
    drive(1'b0, 1'b1, 1024, 0); wait_free();

    // reset at accept+10 aborts; next sample sees prev=0
    drive(1'b0, 1'b1, 3000, -2000);
    repeat (9) drive(1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 1024, 0, 1'b1, 1190); wait_free();

    // strobe held continuously with changing data
    repeat (5 * PERIOD + 3) drive(1'b0, 1'b1, rnd(), rnd());
    drive(1'b0, 1'b0, 0, 0);
    wait_free();

    // random traffic with occasional resets
    repeat (1500) drive($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, rnd(), rnd());

    repeat (45) drive(1'b0, 1'b0, 0, 0);
    chk("queue_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
